// File: rtl/vga_draw_scheduler_pkg.sv
// Shared definitions for the VGA draw scheduler: screen bounds, default widths
// and the scheduler state encoding.
package vga_draw_scheduler_pkg;

  localparam int NREQ_DEF    = 3;
  localparam int X_W_DEF     = 8;
  localparam int Y_W_DEF     = 7;
  localparam int COLOR_W_DEF = 3;
  localparam int X_MAX_DEF   = 159;
  localparam int Y_MAX_DEF   = 119;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

endpackage

// File: rtl/vga_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping around; returns a one-hot grant plus its index.
module vga_draw_scheduler_rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = PTR_W'((int'(ptr) + i) % NREQ);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the VGA adapter pixel port between several filled-rectangle requesters:
// round-robin grant, then one pixel per clock until the rectangle is complete.
module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*X_W-1:0]     req_x,
  input  logic [NREQ*Y_W-1:0]     req_y,
  input  logic [NREQ*X_W-1:0]     req_w,
  input  logic [NREQ*Y_W-1:0]     req_h,
  input  logic [NREQ*COLOR_W-1:0] req_color,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COLOR_W-1:0]      color,
  output logic                    plot
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, arb_idx;
  logic [NREQ-1:0]      arb_gnt, owner_q;
  logic                 arb_any, arb_go, zero_cmd, skip_q;
  logic                 wrap_x, last_px, px_on;
  logic [X_W-1:0]       cmd_x, cmd_w, x0_q, w_q, cx_q;
  logic [Y_W-1:0]       cmd_y, cmd_h, y0_q, h_q, cy_q;
  logic [COLOR_W-1:0]   cmd_color, color_q;
  logic [X_W:0]         sx;
  logic [Y_W:0]         sy;

  // Sums are one bit wider than the screen coordinates so off-screen pixels are seen.
  function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
    return (int'(px) <= X_MAX) && (int'(py) <= Y_MAX);
  endfunction

  vga_draw_scheduler_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        cmd_x     = req_x[i*X_W +: X_W];
        cmd_y     = req_y[i*Y_W +: Y_W];
        cmd_w     = req_w[i*X_W +: X_W];
        cmd_h     = req_h[i*Y_W +: Y_W];
        cmd_color = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // A zero-size grant leaves a pending done that blocks arbitration for one cycle.
  assign arb_go   = (state_q == IDLE) && !skip_q && arb_any;
  assign zero_cmd = (cmd_w == '0) || (cmd_h == '0);
  assign wrap_x   = (cx_q == w_q - X_W'(1));
  assign last_px  = wrap_x && (cy_q == h_q - Y_W'(1));
  assign sx       = {1'b0, x0_q} + {1'b0, cx_q};
  assign sy       = {1'b0, y0_q} + {1'b0, cy_q};
  assign px_on    = on_screen(sx, sy);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_go && !zero_cmd) state_d = DRAW;
      DRAW:    if (last_px) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      owner_q <= '0;
      skip_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      color   <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      plot <= 1'b0;
      if (state_q == DRAW) begin
        busy  <= 1'b1;
        plot  <= px_on;
        x     <= sx[X_W-1:0];
        y     <= sy[Y_W-1:0];
        color <= color_q;
        if (last_px) begin
          done <= owner_q;
        end else if (wrap_x) begin
          cx_q <= '0;
          cy_q <= cy_q + Y_W'(1);
        end else begin
          cx_q <= cx_q + X_W'(1);
        end
      end else if (skip_q) begin
        skip_q <= 1'b0;
        done   <= owner_q;
        busy   <= 1'b1;
      end else if (arb_go) begin
        gnt     <= arb_gnt;
        owner_q <= arb_gnt;
        busy    <= 1'b1;
        skip_q  <= zero_cmd;
        cx_q    <= '0;
        cy_q    <= '0;
        ptr_q   <= (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + PTR_W'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  // Command data is captured at grant and needs no reset.
  always_ff @(posedge clk) begin
    if (arb_go) begin
      x0_q    <= cmd_x;
      y0_q    <= cmd_y;
      w_q     <= cmd_w;
      h_q     <= cmd_h;
      color_q <= cmd_color;
    end
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Self-checking bench for vga_draw_scheduler: directed and randomized commands
// compared against a rectangle-scan reference model.
module tb_vga_draw_scheduler;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [23:0] req_w;
  logic [20:0] req_h;
  logic [8:0]  req_color;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;

  int checks;
  int errors;
  int m_ptr;

  vga_draw_scheduler dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_w     (req_w),
    .req_h     (req_h),
    .req_color (req_color),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .x         (x),
    .y         (y),
    .color     (color),
    .plot      (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int r, input int xx, input int yy, input int ww,
                         input int hh, input int cc);
    req_x[r*8 +: 8]     = 8'(xx);
    req_y[r*7 +: 7]     = 7'(yy);
    req_w[r*8 +: 8]     = 8'(ww);
    req_h[r*7 +: 7]     = 7'(hh);
    req_color[r*3 +: 3] = 3'(cc);
  endtask

  // Round-robin rule: lowest requesting index >= p, otherwise lowest overall.
  function automatic int rr_pick(input logic [2:0] m, input int p);
    for (int i = p; i < 3; i++) if (m[i]) return i;
    for (int i = 0; i < p; i++) if (m[i]) return i;
    return 0;
  endfunction

  // One requester alone; walks the expected raster of the rectangle.
  task automatic run_single(input int r, input int xx, input int yy, input int ww,
                            input int hh, input int cc);
    int ex, ey, last;
    logic [2:0] oh;
    oh = 3'(1 << r);
    set_cmd(r, xx, yy, ww, hh, cc);
    req = oh;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(oh));
    check("busy_at_gnt", 32'(busy), 32'd1);
    check("plot_at_gnt", 32'(plot), 32'd0);
    m_ptr = (r + 1) % 3;
    req = 3'b000;
    set_cmd(r, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(1, 9),
            $urandom_range(1, 9), $urandom_range(0, 7));
    if (ww == 0 || hh == 0) begin
      @(negedge clk);
      check("degen_done", 32'(done), 32'(oh));
      check("degen_plot", 32'(plot), 32'd0);
      check("degen_busy", 32'(busy), 32'd1);
    end else begin
      for (int row = 0; row < hh; row++) begin
        for (int col = 0; col < ww; col++) begin
          @(negedge clk);
          ex   = xx + col;
          ey   = yy + row;
          last = (row == hh - 1 && col == ww - 1) ? 1 : 0;
          check("plot", 32'(plot), (ex <= 159 && ey <= 119) ? 32'd1 : 32'd0);
          check("x", 32'(x), 32'(ex % 256));
          check("y", 32'(y), 32'(ey % 128));
          check("color", 32'(color), 32'(cc));
          check("done", 32'(done), last ? 32'(oh) : 32'd0);
          check("busy", 32'(busy), 32'd1);
        end
      end
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done_plot", 32'({done, plot}), 32'd0);
  endtask

  // All requesters in mask held high, 1x1 commands; grant order follows the pointer.
  task automatic run_contention(input logic [2:0] mask);
    int xs[3];
    int ys[3];
    int cs[3];
    int w;
    for (int i = 0; i < 3; i++) begin
      xs[i] = $urandom_range(0, 159);
      ys[i] = $urandom_range(0, 119);
      cs[i] = $urandom_range(0, 7);
      set_cmd(i, xs[i], ys[i], 1, 1, cs[i]);
    end
    req = mask;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      w = rr_pick(mask, m_ptr);
      check("cont_gnt", 32'(gnt), 32'(1 << w));
      check("cont_gnt_plot", 32'(plot), 32'd0);
      m_ptr = (w + 1) % 3;
      @(negedge clk);
      check("cont_done", 32'(done), 32'(1 << w));
      check("cont_gap", 32'(gnt), 32'd0);
      check("cont_plot", 32'(plot), 32'd1);
      check("cont_xy", 32'({x, y}), 32'((xs[w] << 7) | ys[w]));
      check("cont_color", 32'(color), 32'(cs[w]));
    end
    req = 3'b000;
    @(negedge clk);
    check("cont_idle", 32'({busy, gnt}), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_ptr     = 0;
    resetn    = 1'b0;
    req       = 3'b000;
    req_x     = '0;
    req_y     = '0;
    req_w     = '0;
    req_h     = '0;
    req_color = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({gnt, done, busy, plot, x, y, color}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'({gnt, busy, plot}), 32'd0);

    run_single(0, 10, 20, 3, 2, 3'b100);
    run_single(2, 158, 119, 4, 2, 3'b011);
    run_single(1, 254, 126, 4, 3, 3'b110);
    run_single(1, 5, 5, 0, 5, 3'b001);
    run_single(0, 5, 5, 7, 0, 3'b010);

    run_contention(3'b111);
    run_contention(3'($urandom_range(1, 7)));
    run_contention(3'($urandom_range(1, 7)));

    for (int n = 0; n < 25; n++) begin
      run_single($urandom_range(0, 2), $urandom_range(0, 170), $urandom_range(0, 127),
                 $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
    end

    // Abort a 10x10 fill partway through.
    set_cmd(0, 0, 0, 10, 10, 5);
    req = 3'b001;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd1);
    m_ptr = 1;
    req = 3'b000;
    repeat (3) @(negedge clk);
    check("abort_pre_x", 32'({plot, x}), 32'h102);
    resetn = 1'b0;
    #1;
    check("abort_outs", 32'({gnt, done, busy, plot, x, y, color}), 32'd0);
    m_ptr = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 32'({done, plot}), 32'd0);
    end
    set_cmd(0, 30, 40, 1, 1, 6);
    set_cmd(1, 50, 60, 1, 1, 2);
    req    = 3'b011;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_gnt", 32'(gnt), 32'(1 << rr_pick(3'b011, m_ptr)));
    req = 3'b000;
    @(negedge clk);
    check("post_reset_done", 32'(done), 32'd1);
    check("post_reset_xy", 32'({plot, x, y}), 32'((1 << 15) | (30 << 7) | 40));
    @(negedge clk);
    check("post_reset_idle", 32'({busy, done, plot}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
